// File: rtl/universal_shift_register_n_pkg.sv
// Shared types for the universal shift register: operation modes and
// the bit-counter width helper.
package usr_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHL  = 3'b001,
        MODE_SHR  = 3'b010,
        MODE_ROL  = 3'b011,
        MODE_ROR  = 3'b100,
        MODE_SIPO = 3'b101,
        MODE_PISO = 3'b110,
        MODE_RSVD = 3'b111
    } mode_e;

    // Counter must hold 0..WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/universal_shift_register_n_if.sv
// Control, data and status bundle of the universal shift register.
interface universal_shift_register_n_if
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic             enable;
    logic [2:0]       mode;
    logic             load;
    logic             ser_in;
    logic [WIDTH-1:0] parallel_in;
    logic             ser_out;
    logic [WIDTH-1:0] reg_data;
    logic [WIDTH-1:0] parallel_out;
    logic             frame_valid;
    logic             busy;
    logic             tx_done;
    logic [CNT_W-1:0] bit_cnt;

    modport master (
        output enable, mode, load, ser_in, parallel_in,
        input  ser_out, reg_data, parallel_out, frame_valid, busy, tx_done, bit_cnt
    );

    modport slave (
        input  enable, mode, load, ser_in, parallel_in,
        output ser_out, reg_data, parallel_out, frame_valid, busy, tx_done, bit_cnt
    );

endinterface

// File: rtl/universal_shift_register_n_bit_counter.sv
// Frame bit counter: clear, increment, and a flag on the last bit of a frame.
module usr_bit_counter
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_wrap
);
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign o_wrap = (r_cnt == CNT_W'(WIDTH - 1));
    assign o_cnt  = r_cnt;

    // Clear and increment together means the frame restarts and counts its first bit.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = i_inc ? CNT_W'(1) : '0;
        end else if (i_inc) begin
            w_cnt_nxt = o_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/universal_shift_register_n.sv
// N-bit universal shift register: shift/rotate, parallel load, and framed
// SIPO receive / PISO transmit with completion pulses.
module universal_shift_register_n
    import usr_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input logic                         clk,
    input logic                         rst,
    universal_shift_register_n_if.slave bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);

    logic [WIDTH-1:0] r_data;
    logic             r_ser;
    logic [WIDTH-1:0] r_pout;
    logic             r_fv;
    logic             r_txd;
    logic             r_busy;
    mode_e            r_prev_mode;

    mode_e            w_mode;
    logic [WIDTH-1:0] w_data_nxt;
    logic             w_ser_nxt;
    logic [WIDTH-1:0] w_pout_nxt;
    logic             w_fv_nxt;
    logic             w_txd_nxt;
    logic             w_busy_nxt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic [CNT_W-1:0] w_cnt;
    logic             w_cnt_wrap;
    logic             w_mode_clr;
    logic             w_busy_eff;
    logic             w_last;
    logic [WIDTH-1:0] w_shl;

    assign w_mode = mode_e'(bus.mode);

    // Leaving a framed mode abandons the frame before the new mode acts on this edge.
    assign w_mode_clr = ((r_prev_mode == MODE_SIPO) || (r_prev_mode == MODE_PISO)) &&
                        (w_mode != r_prev_mode);
    assign w_busy_eff = r_busy && !w_mode_clr;
    assign w_last     = w_cnt_wrap && !w_mode_clr;
    assign w_shl      = {r_data[WIDTH-2:0], bus.ser_in};

    usr_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (bus.enable && w_cnt_clr),
        .i_inc  (bus.enable && w_cnt_inc),
        .o_cnt  (w_cnt),
        .o_wrap (w_cnt_wrap)
    );

    always_comb begin
        w_data_nxt = r_data;
        w_ser_nxt  = r_ser;
        w_pout_nxt = r_pout;
        w_fv_nxt   = 1'b0;
        w_txd_nxt  = 1'b0;
        w_busy_nxt = w_busy_eff;
        w_cnt_clr  = w_mode_clr;
        w_cnt_inc  = 1'b0;
        if (bus.load) begin
            w_data_nxt = bus.parallel_in;
            w_cnt_clr  = 1'b1;
            w_busy_nxt = (w_mode == MODE_PISO);
        end else begin
            unique case (w_mode)
                MODE_SHL: begin
                    w_data_nxt = w_shl;
                    w_ser_nxt  = r_data[WIDTH-1];
                end
                MODE_SHR: begin
                    w_data_nxt = {bus.ser_in, r_data[WIDTH-1:1]};
                    w_ser_nxt  = r_data[0];
                end
                MODE_ROL: begin
                    w_data_nxt = {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                    w_ser_nxt  = r_data[WIDTH-1];
                end
                MODE_ROR: begin
                    w_data_nxt = {r_data[0], r_data[WIDTH-1:1]};
                    w_ser_nxt  = r_data[0];
                end
                MODE_SIPO: begin
                    w_data_nxt = w_shl;
                    w_ser_nxt  = r_data[WIDTH-1];
                    w_cnt_inc  = 1'b1;
                    if (w_last) begin
                        w_pout_nxt = w_shl;
                        w_fv_nxt   = 1'b1;
                    end
                end
                MODE_PISO: begin
                    if (w_busy_eff) begin
                        w_data_nxt = {r_data[WIDTH-2:0], 1'b0};
                        w_ser_nxt  = r_data[WIDTH-1];
                        w_cnt_inc  = 1'b1;
                        if (w_last) begin
                            w_busy_nxt = 1'b0;
                            w_txd_nxt  = 1'b1;
                        end
                    end
                end
                MODE_HOLD, MODE_RSVD: ;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data      <= RESET_VAL;
            r_ser       <= 1'b0;
            r_pout      <= '0;
            r_fv        <= 1'b0;
            r_txd       <= 1'b0;
            r_busy      <= 1'b0;
            r_prev_mode <= MODE_HOLD;
        end else if (!bus.enable) begin
            r_fv  <= 1'b0;
            r_txd <= 1'b0;
        end else begin
            r_data      <= w_data_nxt;
            r_ser       <= w_ser_nxt;
            r_pout      <= w_pout_nxt;
            r_fv        <= w_fv_nxt;
            r_txd       <= w_txd_nxt;
            r_busy      <= w_busy_nxt;
            r_prev_mode <= w_mode;
        end
    end

    assign bus.ser_out      = r_ser;
    assign bus.reg_data     = r_data;
    assign bus.parallel_out = r_pout;
    assign bus.frame_valid  = r_fv;
    assign bus.busy         = r_busy;
    assign bus.tx_done      = r_txd;
    assign bus.bit_cnt      = w_cnt;

endmodule

// File: tb/tb_universal_shift_register_n.sv
// Directed bench for universal_shift_register_n at WIDTH=8.
module tb_universal_shift_register_n;
    import usr_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   fv_cnt;
    int   txd_cnt;
    int   busy_cnt;
    logic [7:0] bits;

    universal_shift_register_n_if #(.WIDTH(8)) bus ();

    universal_shift_register_n #(
        .WIDTH     (8),
        .RESET_VAL (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_valid) fv_cnt++;
        if (bus.tx_done) txd_cnt++;
        if (bus.busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        fv_cnt = 0;
        txd_cnt = 0;
        busy_cnt = 0;
        rst = 1'b0;
        bus.enable = 1'b0;
        bus.mode = MODE_HOLD;
        bus.load = 1'b0;
        bus.ser_in = 1'b0;
        bus.parallel_in = 8'h00;
        tick();
        tick();
        rst = 1'b1;

        // Activity, then reset
        bus.enable = 1'b1;
        bus.load = 1'b1;
        bus.parallel_in = 8'hFF;
        tick();
        bus.load = 1'b0;
        bus.mode = MODE_SHL;
        bus.ser_in = 1'b1;
        tick();
        check("pre_rst_ser", 32'(bus.ser_out), 32'h1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst_reg", 32'(bus.reg_data), 32'h00);
        check("rst_ser", 32'(bus.ser_out), 32'h0);
        check("rst_pout", 32'(bus.parallel_out), 32'h00);
        check("rst_fv", 32'(bus.frame_valid), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_txd", 32'(bus.tx_done), 32'h0);
        check("rst_cnt", 32'(bus.bit_cnt), 32'h0);

        // Load then SHL
        bus.mode = MODE_HOLD;
        bus.load = 1'b1;
        bus.parallel_in = 8'hA5;
        tick();
        check("load_a5", 32'(bus.reg_data), 32'hA5);
        bus.load = 1'b0;
        bus.mode = MODE_SHL;
        bus.ser_in = 1'b1;
        tick();
        check("shl_reg", 32'(bus.reg_data), 32'h4B);
        check("shl_ser", 32'(bus.ser_out), 32'h1);
        bus.enable = 1'b0;
        bus.load = 1'b1;
        bus.parallel_in = 8'h3C;
        tick();
        check("en0_reg", 32'(bus.reg_data), 32'h4B);
        check("en0_ser", 32'(bus.ser_out), 32'h1);
        bus.enable = 1'b1;
        bus.load = 1'b0;

        // SHR then ROL
        bus.mode = MODE_SHR;
        bus.ser_in = 1'b0;
        tick();
        check("shr_reg", 32'(bus.reg_data), 32'h25);
        check("shr_ser", 32'(bus.ser_out), 32'h1);
        bus.mode = MODE_ROL;
        tick();
        check("rol_reg", 32'(bus.reg_data), 32'h4A);
        check("rol_ser", 32'(bus.ser_out), 32'h0);

        // ROR
        bus.mode = MODE_HOLD;
        bus.load = 1'b1;
        bus.parallel_in = 8'h81;
        tick();
        bus.load = 1'b0;
        bus.mode = MODE_ROR;
        tick();
        check("ror1_reg", 32'(bus.reg_data), 32'hC0);
        check("ror1_ser", 32'(bus.ser_out), 32'h1);
        for (int i = 0; i < 7; i++) tick();
        check("ror8_reg", 32'(bus.reg_data), 32'h81);

        // SIPO with a 3-cycle stall after bit 4
        fv_cnt = 0;
        bus.mode = MODE_SIPO;
        bits = 8'b1011_0010;
        for (int i = 7; i >= 4; i--) begin
            bus.ser_in = bits[i];
            tick();
        end
        check("sipo_cnt4", 32'(bus.bit_cnt), 32'h4);
        bus.enable = 1'b0;
        tick();
        tick();
        tick();
        check("stall_cnt", 32'(bus.bit_cnt), 32'h4);
        check("stall_fv", 32'(bus.frame_valid), 32'h0);
        bus.enable = 1'b1;
        for (int i = 3; i >= 1; i--) begin
            bus.ser_in = bits[i];
            tick();
        end
        check("sipo_cnt7", 32'(bus.bit_cnt), 32'h7);
        check("sipo_fv7", 32'(bus.frame_valid), 32'h0);
        bus.ser_in = bits[0];
        tick();
        check("sipo_fv", 32'(bus.frame_valid), 32'h1);
        check("sipo_pout", 32'(bus.parallel_out), 32'hB2);
        check("sipo_cnt0", 32'(bus.bit_cnt), 32'h0);
        bus.mode = MODE_HOLD;
        tick();
        check("sipo_fv_drop", 32'(bus.frame_valid), 32'h0);
        check("pout_hold", 32'(bus.parallel_out), 32'hB2);
        check("fv_pulses", 32'(fv_cnt), 32'h1);

        // PISO full frame
        bus.mode = MODE_PISO;
        bus.load = 1'b1;
        bus.parallel_in = 8'hB2;
        busy_cnt = 0;
        txd_cnt = 0;
        tick();
        bus.load = 1'b0;
        check("piso_busy", 32'(bus.busy), 32'h1);
        check("piso_reg", 32'(bus.reg_data), 32'hB2);
        bits = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            tick();
            bits[i] = bus.ser_out;
        end
        check("piso_bits", 32'(bits), 32'hB2);
        check("piso_txd", 32'(bus.tx_done), 32'h1);
        check("piso_done_busy", 32'(bus.busy), 32'h0);
        check("piso_reg0", 32'(bus.reg_data), 32'h00);
        check("piso_cnt0", 32'(bus.bit_cnt), 32'h0);
        tick();
        check("piso_txd_drop", 32'(bus.tx_done), 32'h0);
        check("busy_cycles", 32'(busy_cnt), 32'h8);
        check("txd_pulses", 32'(txd_cnt), 32'h1);

        // PISO abort by mode change, then reload mid-frame
        txd_cnt = 0;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        tick();
        check("abort_cnt3", 32'(bus.bit_cnt), 32'h3);
        bus.mode = MODE_HOLD;
        tick();
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_cnt", 32'(bus.bit_cnt), 32'h0);
        check("abort_reg", 32'(bus.reg_data), 32'h90);
        bus.mode = MODE_PISO;
        bus.load = 1'b1;
        bus.parallel_in = 8'hFF;
        tick();
        bus.load = 1'b0;
        tick();
        tick();
        check("reload_cnt2", 32'(bus.bit_cnt), 32'h2);
        bus.load = 1'b1;
        bus.parallel_in = 8'hA5;
        tick();
        bus.load = 1'b0;
        check("reload_cnt0", 32'(bus.bit_cnt), 32'h0);
        check("reload_busy", 32'(bus.busy), 32'h1);
        for (int i = 0; i < 8; i++) tick();
        check("reload_txd", 32'(bus.tx_done), 32'h1);
        check("reload_ser", 32'(bus.ser_out), 32'h1);
        tick();
        check("reload_pulses", 32'(txd_cnt), 32'h1);
        check("reload_reg", 32'(bus.reg_data), 32'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
